// File: rtl/axioma_alu_sequencer.sv
// Issue sequencer for the 8-bit ALU: operand fetch, ALU drive, GPR/SREG writeback.
// Byte ops retire in 2 cycles after accept, ADIW/SBIW in 3; accepts only when idle.
module axioma_alu_sequencer #(
  parameter int RA_W    = 5,
  parameter bit WORD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [RA_W-1:0] req_rd,
  input  logic [RA_W-1:0] req_rr,
  input  logic [7:0]      req_imm,
  input  logic            req_use_imm,
  input  logic            req_word,
  output logic [RA_W-1:0] rf_raddr_a,
  output logic [RA_W-1:0] rf_raddr_b,
  input  logic [7:0]      rf_rdata_a,
  input  logic [7:0]      rf_rdata_b,
  output logic [7:0]      alu_operand_a,
  output logic [7:0]      alu_operand_b,
  output logic [4:0]      alu_op,
  output logic [5:0]      alu_flags_in,
  input  logic [7:0]      alu_result,
  input  logic [5:0]      alu_flags_out,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [7:0]      rf_wdata,
  input  logic [7:0]      sreg_in,
  output logic            sreg_we,
  output logic [7:0]      sreg_wdata,
  output logic            done,
  output logic            done_err
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_ADC = 5'd1,  OP_SUB  = 5'd2,  OP_SBC  = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4,  OP_OR  = 5'd5,  OP_EOR  = 5'd6,  OP_COM  = 5'd7;
  localparam logic [4:0] OP_NEG = 5'd8,  OP_INC = 5'd9,  OP_DEC  = 5'd10, OP_LSL  = 5'd11;
  localparam logic [4:0] OP_LSR = 5'd12, OP_ROL = 5'd13, OP_ROR  = 5'd14, OP_ASR  = 5'd15;
  localparam logic [4:0] OP_SWAP = 5'd16, OP_PASS = 5'd17, OP_CP = 5'd18, OP_CPC  = 5'd19;
  localparam logic [4:0] OP_TST = 5'd20;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_EXEC_LO, S_EXEC_HI} state_t;

  state_t          state, state_nxt;
  logic [4:0]      op_q;
  logic [RA_W-1:0] rd_q, rr_q;
  logic [7:0]      imm_q;
  logic            use_imm_q, err_q, c_lo_q, z_lo_q;

  logic            nxt_rf_we, nxt_sreg_we, nxt_done, nxt_done_err;
  logic [RA_W-1:0] nxt_rf_waddr;
  logic [7:0]      nxt_rf_wdata, nxt_sreg_wdata;

  logic            accept, req_illegal, word_ok;
  logic [7:0]      sreg_mask, sreg_byte, sreg_word;
  logic            byte_writes_rf;

  assign req_ready   = (state == S_IDLE) && !done;
  assign accept      = req_valid && req_ready;
  assign word_ok     = WORD_EN && (req_op == OP_ADD || req_op == OP_SUB) && !req_rd[0];
  assign req_illegal = (req_op > OP_TST) || (req_word && !word_ok);

  // Flags each byte op may touch; I and T are never in the mask.
  always_comb begin
    sreg_mask = 8'h00;
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_CPC, OP_NEG, OP_LSL, OP_ROL: sreg_mask = 8'h3F;
      OP_COM, OP_LSR, OP_ROR, OP_ASR:                                       sreg_mask = 8'h1F;
      OP_AND, OP_OR, OP_EOR, OP_TST, OP_INC, OP_DEC:                        sreg_mask = 8'h1E;
      default:                                                              sreg_mask = 8'h00;
    endcase
  end

  assign byte_writes_rf = !(op_q == OP_CP || op_q == OP_CPC || op_q == OP_TST);

  // Carry-chained ops can only keep Z set if every earlier byte was zero too.
  always_comb begin
    sreg_byte = (sreg_in & ~sreg_mask) | ({2'b00, alu_flags_out} & sreg_mask);
    if (op_q == OP_SBC || op_q == OP_CPC)
      sreg_byte[1] = alu_flags_out[1] & sreg_in[1];
  end

  assign sreg_word = {sreg_in[7:5], alu_flags_out[4:2], z_lo_q & alu_flags_out[1], alu_flags_out[0]};

  always_comb begin
    state_nxt      = state;
    rf_raddr_a     = '0;
    rf_raddr_b     = '0;
    alu_operand_a  = 8'h00;
    alu_operand_b  = 8'h00;
    alu_op         = 5'd0;
    alu_flags_in   = 6'h00;
    nxt_rf_we      = 1'b0;
    nxt_rf_waddr   = '0;
    nxt_rf_wdata   = 8'h00;
    nxt_sreg_we    = 1'b0;
    nxt_sreg_wdata = 8'h00;
    nxt_done       = 1'b0;
    nxt_done_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept)
          state_nxt = (req_word && !req_illegal) ? S_EXEC_LO : S_EXEC;
      end
      S_EXEC: begin
        rf_raddr_a    = rd_q;
        rf_raddr_b    = rr_q;
        alu_operand_a = rf_rdata_a;
        alu_operand_b = use_imm_q ? imm_q : rf_rdata_b;
        alu_op        = op_q;
        alu_flags_in  = sreg_in[5:0];
        nxt_done      = 1'b1;
        nxt_done_err  = err_q;
        if (!err_q) begin
          nxt_rf_we      = byte_writes_rf;
          nxt_rf_waddr   = rd_q;
          nxt_rf_wdata   = alu_result;
          nxt_sreg_we    = (sreg_mask != 8'h00);
          nxt_sreg_wdata = sreg_byte;
        end
        state_nxt = S_IDLE;
      end
      S_EXEC_LO: begin
        rf_raddr_a    = rd_q;
        alu_operand_a = rf_rdata_a;
        alu_operand_b = imm_q;
        alu_op        = op_q;
        alu_flags_in  = sreg_in[5:0];
        nxt_rf_we     = 1'b1;
        nxt_rf_waddr  = rd_q;
        nxt_rf_wdata  = alu_result;
        state_nxt     = S_EXEC_HI;
      end
      S_EXEC_HI: begin
        rf_raddr_a     = {rd_q[RA_W-1:1], 1'b1};
        alu_operand_a  = rf_rdata_a;
        alu_op         = (op_q == OP_ADD) ? OP_ADC : OP_SBC;
        alu_flags_in   = {sreg_in[5:1], c_lo_q};
        nxt_rf_we      = 1'b1;
        nxt_rf_waddr   = {rd_q[RA_W-1:1], 1'b1};
        nxt_rf_wdata   = alu_result;
        nxt_sreg_we    = 1'b1;
        nxt_sreg_wdata = sreg_word;
        nxt_done       = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= 5'd0;
      rd_q       <= '0;
      rr_q       <= '0;
      imm_q      <= 8'h00;
      use_imm_q  <= 1'b0;
      err_q      <= 1'b0;
      c_lo_q     <= 1'b0;
      z_lo_q     <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= 8'h00;
      sreg_we    <= 1'b0;
      sreg_wdata <= 8'h00;
      done       <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rf_we      <= nxt_rf_we;
      rf_waddr   <= nxt_rf_waddr;
      rf_wdata   <= nxt_rf_wdata;
      sreg_we    <= nxt_sreg_we;
      sreg_wdata <= nxt_sreg_wdata;
      done       <= nxt_done;
      done_err   <= nxt_done_err;
      if (accept) begin
        op_q      <= req_op;
        rd_q      <= req_rd;
        rr_q      <= req_rr;
        imm_q     <= req_imm;
        use_imm_q <= req_use_imm;
        err_q     <= req_illegal;
      end
      if (state == S_EXEC_LO) begin
        c_lo_q <= alu_flags_out[0];
        z_lo_q <= alu_flags_out[1];
      end
    end
  end

endmodule
